// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates MSHR and icache requests onto one memory port and routes load returns by tag.
//   clock, reset (async, active-low)
//   dc_command/dc_addr/dc_data        : MSHR request
//   ic_command/ic_addr                : icache request (loads only)
//   mem2proc_response/_data/_tag      : memory accept tag and load return
//   proc2mem_command/_addr/_data      : granted request to memory
//   dc_response/ic_response           : accept tag for the granted requester
//   dc_mem_tag/_data, ic_mem_tag/_data: load return routed to its owner
//   outstanding                       : loads in flight (saturates at 15)
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  dc_command,
    input  logic [63:0] dc_addr,
    input  logic [63:0] dc_data,
    input  logic [1:0]  ic_command,
    input  logic [63:0] ic_addr,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  dc_response,
    output logic [3:0]  ic_response,
    output logic [3:0]  dc_mem_tag,
    output logic [63:0] dc_mem_data,
    output logic [3:0]  ic_mem_tag,
    output logic [63:0] ic_mem_data,
    output logic [4:0]  outstanding
);
    localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1;
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    logic [NUM_TAGS-1:0] tag_valid, tag_owner;
    logic [2:0] starve_cnt;
    logic ic_load, ic_grant, dc_grant, accepted, alloc, ret_hit, ret_ic;
    always_comb begin
        ic_load          = ic_command == BUS_LOAD;
        ic_grant         = ic_load && (starve_cnt == LIMIT || dc_command == BUS_NONE);
        dc_grant         = !ic_grant && dc_command != BUS_NONE;
        proc2mem_command = dc_grant ? dc_command : ic_grant ? BUS_LOAD : BUS_NONE;
        proc2mem_addr    = dc_grant ? dc_addr : ic_grant ? ic_addr : '0;
        proc2mem_data    = dc_grant ? dc_data : '0;
        dc_response      = dc_grant ? mem2proc_response : '0;
        ic_response      = ic_grant ? mem2proc_response : '0;
        accepted         = (dc_grant || ic_grant) && mem2proc_response != '0;
        alloc            = accepted && proc2mem_command == BUS_LOAD;
        // routing uses the table as it stands before this edge, so a same-tag allocation cannot steal the return
        ret_hit          = mem2proc_tag != '0 && tag_valid[mem2proc_tag];
        ret_ic           = ret_hit && tag_owner[mem2proc_tag];
        dc_mem_tag       = ret_hit && !ret_ic ? mem2proc_tag : '0;
        dc_mem_data      = ret_hit && !ret_ic ? mem2proc_data : '0;
        ic_mem_tag       = ret_ic ? mem2proc_tag : '0;
        ic_mem_data      = ret_ic ? mem2proc_data : '0;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid   <= '0;
            tag_owner   <= '0;
            starve_cnt  <= '0;
            outstanding <= '0;
        end else begin
            if (ret_hit) tag_valid[mem2proc_tag] <= 1'b0;
            // allocation is written last so it wins over a same-tag return
            if (alloc) begin
                tag_valid[mem2proc_response] <= 1'b1;
                tag_owner[mem2proc_response] <= ic_grant;
            end
            if (alloc && !ret_hit && outstanding != 5'd15) outstanding <= outstanding + 5'd1;
            else if (!alloc && ret_hit && outstanding != 5'd0) outstanding <= outstanding - 5'd1;
            if (!ic_load || (ic_grant && accepted)) starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter grant, routing, starvation and reset behaviour.
module tb_mem_arbiter;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr, data, dcd, icd;
        logic [3:0]  dcr, icr, dct, ict;
        logic [4:0]  outs;
        logic [2:0]  stv;
    } exp_t;
    logic        clock = 1'b0, reset = 1'b0;
    logic [1:0]  dc_command = '0, ic_command = '0;
    logic [63:0] dc_addr = '0, dc_data = '0, ic_addr = '0, mem2proc_data = '0;
    logic [3:0]  mem2proc_response = '0, mem2proc_tag = '0;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr, proc2mem_data, dc_mem_data, ic_mem_data;
    logic [3:0]  dc_response, ic_response, dc_mem_tag, ic_mem_tag;
    logic [4:0]  outstanding;
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
        .ic_command(ic_command), .ic_addr(ic_addr),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .dc_response(dc_response), .ic_response(ic_response),
        .dc_mem_tag(dc_mem_tag), .dc_mem_data(dc_mem_data),
        .ic_mem_tag(ic_mem_tag), .ic_mem_data(ic_mem_data),
        .outstanding(outstanding)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // g: expected grantee (0 none, 1 dc, 2 ic); r: expected return owner (0 dropped, 1 dc, 2 ic);
    // outs/stv: expected outstanding and starve count as seen before this cycle's edge
    task automatic cyc(input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                       input logic [1:0] icc, input logic [63:0] ica, input logic [3:0] rsp,
                       input logic [3:0] mt, input logic [63:0] md,
                       input int g, input int r, input int outs, input int stv);
        exp_t e, o;
        dc_command = dcc; dc_addr = dca; dc_data = dcd;
        ic_command = icc; ic_addr = ica;
        mem2proc_response = rsp; mem2proc_tag = mt; mem2proc_data = md;
        e.cmd  = g == 1 ? dcc : g == 2 ? LOAD : NONE;
        e.addr = g == 1 ? dca : g == 2 ? ica : 64'd0;
        e.data = g == 1 ? dcd : 64'd0;
        e.dcr  = g == 1 ? rsp : 4'd0;
        e.icr  = g == 2 ? rsp : 4'd0;
        e.dct  = r == 1 ? mt : 4'd0;
        e.dcd  = r == 1 ? md : 64'd0;
        e.ict  = r == 2 ? mt : 4'd0;
        e.icd  = r == 2 ? md : 64'd0;
        e.outs = 5'(outs);
        e.stv  = 3'(stv);
        sb.push_back(e);
        #2;
        o = sb.pop_front();
        check("cmd", proc2mem_command, o.cmd);
        check("addr", proc2mem_addr, o.addr);
        check("data", proc2mem_data, o.data);
        check("dc_resp", dc_response, o.dcr);
        check("ic_resp", ic_response, o.icr);
        check("dc_tag", dc_mem_tag, o.dct);
        check("dc_mdata", dc_mem_data, o.dcd);
        check("ic_tag", ic_mem_tag, o.ict);
        check("ic_mdata", ic_mem_data, o.icd);
        check("outstanding", outstanding, o.outs);
        check("starve", dut.starve_cnt, o.stv);
        @(negedge clock);
    endtask
    task automatic idle(input int outs, input int stv);
        cyc(NONE, 0, 0, NONE, 0, 0, 0, 0, 0, 0, outs, stv);
    endtask
    initial begin
        idle(0, 0);
        reset = 1'b1;
        // single dc load then its return
        cyc(LOAD, 64'h100, 0, NONE, 0, 4'd3, 0, 0, 1, 0, 0, 0);
        cyc(NONE, 0, 0, NONE, 0, 0, 4'd3, 64'hDEAD, 0, 1, 1, 0);
        idle(0, 0);
        // store allocates nothing, its tag return is dropped
        cyc(STORE, 64'h200, 64'h55, NONE, 0, 4'd7, 0, 0, 1, 0, 0, 0);
        cyc(NONE, 0, 0, NONE, 0, 0, 4'd7, 64'h77, 0, 0, 0, 0);
        // icache store is ignored
        cyc(NONE, 0, 0, STORE, 64'h300, 4'd4, 0, 0, 0, 0, 0, 0);
        // contention: dc wins four times, ic on the fifth, then dc again
        for (int i = 0; i < 6; i++)
            cyc(LOAD, 64'h1000 + 64'(i), 64'(i), LOAD, 64'h2000 + 64'(i), 4'(i + 1), 0, 0,
                i == 4 ? 2 : 1, 0, i, i < 5 ? i : 0);
        for (int i = 0; i < 6; i++)
            cyc(NONE, 0, 0, NONE, 0, 0, 4'(i + 1), 64'hA0 + 64'(i), 0, i == 4 ? 2 : 1, 6 - i, i == 0 ? 1 : 0);
        idle(0, 0);
        // starved ic keeps priority while memory refuses it
        for (int i = 0; i < 4; i++)
            cyc(LOAD, 64'h4000, 0, LOAD, 64'h5000, 4'(i + 1), 0, 0, 1, 0, i, i);
        for (int i = 0; i < 3; i++)
            cyc(LOAD, 64'h4000, 0, LOAD, 64'h5000, 0, 0, 0, 2, 0, 4, 4);
        cyc(LOAD, 64'h4000, 0, LOAD, 64'h5000, 4'd9, 0, 0, 2, 0, 4, 4);
        idle(5, 0);
        for (int i = 0; i < 4; i++)
            cyc(NONE, 0, 0, NONE, 0, 0, 4'(i + 1), 64'hB0 + 64'(i), 0, 1, 5 - i, 0);
        cyc(NONE, 0, 0, NONE, 0, 0, 4'd9, 64'hC9, 0, 2, 1, 0);
        idle(0, 0);
        // same-tag return and allocation: old owner gets data, new owner keeps the tag
        cyc(LOAD, 64'h500, 0, NONE, 0, 4'd5, 0, 0, 1, 0, 0, 0);
        cyc(NONE, 0, 0, LOAD, 64'h600, 4'd5, 4'd5, 64'hBEEF, 2, 1, 1, 0);
        check("tag5_valid", dut.tag_valid[5], 1'b1);
        check("tag5_owner", dut.tag_owner[5], 1'b1);
        idle(1, 0);
        cyc(NONE, 0, 0, NONE, 0, 0, 4'd5, 64'hF00D, 0, 2, 1, 0);
        idle(0, 0);
        // loads in flight across reset are dropped
        cyc(LOAD, 64'h700, 0, NONE, 0, 4'd1, 0, 0, 1, 0, 0, 0);
        cyc(LOAD, 64'h708, 0, NONE, 0, 4'd2, 0, 0, 1, 0, 1, 0);
        reset = 1'b0;
        idle(0, 0);
        reset = 1'b1;
        cyc(NONE, 0, 0, NONE, 0, 0, 4'd1, 64'h11, 0, 0, 0, 0);
        idle(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
